// File: rtl/sram_sched_pkg.sv
// Shared types and helpers for the two-requester SRAM port scheduler.
package sram_sched_pkg;

    localparam int unsigned NUM_BANKS = 2;
    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } size_e;

    function automatic logic [NUM_LANES-1:0] lane_decode(input size_e sz, input logic [1:0] off);
        logic [NUM_LANES-1:0] lanes;
        case (sz)
            BYTE:    lanes = 4'b0001 << off;
            HALF:    lanes = off[1] ? 4'b1100 : 4'b0011;
            WORD:    lanes = 4'b1111;
            default: lanes = '0;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/sram_if.sv
// Bus between the scheduler and the two banks of byte-lane SRAM macros.
interface sram_if #(
    parameter int unsigned SRAM_DATA_WIDTH = 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH      = 32
);
    localparam int unsigned LANES = DATA_WIDTH / SRAM_DATA_WIDTH;

    logic                       sram_we;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0]      sram_wdata;
    logic [LANES-1:0]           bank0_cs;
    logic [LANES-1:0]           bank1_cs;
    logic [SRAM_DATA_WIDTH-1:0] sram_b0, sram_b1, sram_b2, sram_b3;
    logic [SRAM_DATA_WIDTH-1:0] sram_b4, sram_b5, sram_b6, sram_b7;

    modport master (
        output sram_we, sram_addr, sram_wdata, bank0_cs, bank1_cs,
        input  sram_b0, sram_b1, sram_b2, sram_b3, sram_b4, sram_b5, sram_b6, sram_b7
    );

    modport slave (
        input  sram_we, sram_addr, sram_wdata, bank0_cs, bank1_cs,
        output sram_b0, sram_b1, sram_b2, sram_b3, sram_b4, sram_b5, sram_b6, sram_b7
    );

endinterface

// File: rtl/sram_lane_dec.sv
// Combinational size/offset decode: per-bank chip selects plus misalignment error.
module sram_lane_dec
    import sram_sched_pkg::*;
(
    input  logic [1:0]                          i_size,
    input  logic [1:0]                          i_offset,
    input  logic                                i_bank,
    output logic [NUM_BANKS-1:0][NUM_LANES-1:0] o_cs,
    output logic                                o_err
);

    size_e w_size;

    always_comb begin
        w_size = size_e'(i_size);
        o_err  = 1'b0;
        o_cs   = '0;
        case (w_size)
            HALF:    o_err = i_offset[0];
            WORD:    o_err = |i_offset;
            ILLEGAL: o_err = 1'b1;
            default: o_err = 1'b0;
        endcase
        if (!o_err) begin
            o_cs[i_bank] = lane_decode(w_size, i_offset);
        end
    end

endmodule

// File: rtl/sram_port_sched.sv
// Two-requester scheduler onto banked byte-lane SRAM; round-robin arbitration,
// or fixed priority to requester 0 when SRAM_SCHED_FIXED_PRIO_EN is defined.
module sram_port_sched
    import sram_sched_pkg::*;
#(
    parameter int unsigned SRAM_DATA_WIDTH = 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH      = 32
)(
    input  logic                                 hclk,
    input  logic                                 hreset,
    input  logic [1:0]                           req,
    input  logic [1:0]                           req_we,
    input  logic [1:0][SRAM_ADDR_WIDTH+2:0]      req_addr,
    input  logic [1:0][1:0]                      req_size,
    input  logic [1:0][DATA_WIDTH-1:0]           req_wdata,
    output logic [1:0]                           gnt,
    output logic [1:0]                           err,
    output logic [1:0]                           rvalid,
    output logic [DATA_WIDTH-1:0]                rdata,
    sram_if.master                               sram
);

    logic [1:0]                          r_gnt, r_err, r_rd, r_rvalid;
    logic                                r_prio, r_we, r_bank, r_rd_bank;
    logic [NUM_BANKS-1:0][NUM_LANES-1:0] r_cs;
    logic [SRAM_ADDR_WIDTH-1:0]          r_addr;
    logic [DATA_WIDTH-1:0]               r_wdata;

    logic [1:0]                          w_req_eff;
    logic                                w_valid, w_sel, w_we, w_err;
    logic [SRAM_ADDR_WIDTH+2:0]          w_addr;
    logic [1:0]                          w_size;
    logic [DATA_WIDTH-1:0]               w_wdata;
    logic [NUM_BANKS-1:0][NUM_LANES-1:0] w_cs;
    logic [NUM_LANES-1:0][SRAM_DATA_WIDTH-1:0] w_b0, w_b1;

    always_comb begin
        // a requester being granted this cycle is still holding req; mask it
        w_req_eff = req & ~r_gnt;
`ifdef SRAM_SCHED_FIXED_PRIO_EN
        // requester 1 only wins while requester 0 is not asserting at all
        w_valid = w_req_eff[0] | (w_req_eff[1] & ~req[0]);
        w_sel   = ~w_req_eff[0];
`else
        w_valid = |w_req_eff;
        w_sel   = (&w_req_eff) ? r_prio : w_req_eff[1];
`endif
        w_addr  = req_addr[w_sel];
        w_size  = req_size[w_sel];
        w_we    = req_we[w_sel];
        w_wdata = req_wdata[w_sel];
    end

    sram_lane_dec u_lane_dec (
        .i_size   (w_size),
        .i_offset (w_addr[1:0]),
        .i_bank   (w_addr[SRAM_ADDR_WIDTH+2]),
        .o_cs     (w_cs),
        .o_err    (w_err)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_gnt     <= '0;
            r_err     <= '0;
            r_rd      <= '0;
            r_rvalid  <= '0;
            r_prio    <= 1'b0;
            r_we      <= 1'b0;
            r_bank    <= 1'b0;
            r_rd_bank <= 1'b0;
            r_cs      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_gnt     <= '0;
            r_err     <= '0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_cs      <= '0;
            r_rvalid  <= r_rd;
            r_rd_bank <= r_bank;
            if (w_valid) begin
                r_gnt[w_sel] <= 1'b1;
                r_err[w_sel] <= w_err;
                r_rd[w_sel]  <= ~w_err & ~w_we;
                r_prio       <= ~w_sel;
                r_we         <= w_we;
                r_bank       <= w_addr[SRAM_ADDR_WIDTH+2];
                r_cs         <= w_cs;
                r_addr       <= w_addr[SRAM_ADDR_WIDTH+1:2];
                r_wdata      <= w_wdata;
            end
        end
    end

    assign w_b0 = {sram.sram_b3, sram.sram_b2, sram.sram_b1, sram.sram_b0};
    assign w_b1 = {sram.sram_b7, sram.sram_b6, sram.sram_b5, sram.sram_b4};

    assign gnt             = r_gnt;
    assign err             = r_err;
    assign rvalid          = r_rvalid;
    assign rdata           = r_rd_bank ? w_b1 : w_b0;
    assign sram.sram_we    = r_we;
    assign sram.sram_addr  = r_addr;
    assign sram.sram_wdata = r_wdata;
    assign sram.bank0_cs   = r_cs[0];
    assign sram.bank1_cs   = r_cs[1];

endmodule

// File: tb/tb_sram_port_sched.sv
// Bench for sram_port_sched: directed scenarios plus randomized traffic vs a byte-level memory model.
module tb_sram_port_sched;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic                 hclk;
    logic                 hreset;
    logic [1:0]           req, req_we;
    logic [1:0][AW+2:0]   req_addr;
    logic [1:0][1:0]      req_size;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           gnt, err, rvalid;
    logic [DW-1:0]        rdata;

    int unsigned total;
    int unsigned bad;

    sram_if #(.SRAM_DATA_WIDTH(8), .SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if ();

    sram_port_sched #(.SRAM_DATA_WIDTH(8), .SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .err       (err),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram      (u_if)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Synchronous SRAM macros: eight byte lanes, index = bank*4 + lane
    logic [7:0] mem [8][8192];
    logic [7:0] b_q [8];

    always @(posedge hclk) begin
        for (int l = 0; l < 4; l++) begin
            if (u_if.bank0_cs[l]) begin
                if (u_if.sram_we) mem[l][u_if.sram_addr] <= u_if.sram_wdata[8*l +: 8];
                else              b_q[l] <= mem[l][u_if.sram_addr];
            end
            if (u_if.bank1_cs[l]) begin
                if (u_if.sram_we) mem[4+l][u_if.sram_addr] <= u_if.sram_wdata[8*l +: 8];
                else              b_q[4+l] <= mem[4+l][u_if.sram_addr];
            end
        end
    end

    assign u_if.sram_b0 = b_q[0];
    assign u_if.sram_b1 = b_q[1];
    assign u_if.sram_b2 = b_q[2];
    assign u_if.sram_b3 = b_q[3];
    assign u_if.sram_b4 = b_q[4];
    assign u_if.sram_b5 = b_q[5];
    assign u_if.sram_b6 = b_q[6];
    assign u_if.sram_b7 = b_q[7];

    // Reference: flat byte-addressed memory keyed by {bank, word, lane}
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] ref_rd(input int unsigned key);
        return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle();
        req    = '0;
        req_we = '0;
    endtask

    task automatic set_req(input int r, input logic we, input logic [15:0] a,
                           input logic [1:0] sz, input logic [31:0] wd);
        req[r]       = 1'b1;
        req_we[r]    = we;
        req_addr[r]  = a;
        req_size[r]  = sz;
        req_wdata[r] = wd;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        set_req(0, 1'b1, 16'h0010, 2'd2, 32'hFFFF_FFFF);
        tick();
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", err); end
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", rvalid); end
        total++; if (u_if.bank0_cs !== 4'b0000) begin bad++; $display("FAIL rst_cs0 got=%b exp=0000", u_if.bank0_cs); end
        total++; if (u_if.bank1_cs !== 4'b0000) begin bad++; $display("FAIL rst_cs1 got=%b exp=0000", u_if.bank1_cs); end
        total++; if (u_if.sram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", u_if.sram_we); end
        total++; if (u_if.sram_addr !== 13'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", u_if.sram_addr); end
        total++; if (u_if.sram_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", u_if.sram_wdata); end
        hreset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_word_write_read();
        set_req(0, 1'b1, 16'h0010, 2'd2, 32'h1234_5678);
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
        total++; if (u_if.bank0_cs !== 4'b1111) begin bad++; $display("FAIL wr_cs0 got=%b exp=1111", u_if.bank0_cs); end
        total++; if (u_if.sram_addr !== 13'd4) begin bad++; $display("FAIL wr_addr got=%h exp=4", u_if.sram_addr); end
        total++; if (u_if.sram_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%b exp=1", u_if.sram_we); end
        total++; if (u_if.sram_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", u_if.sram_wdata); end
        idle();
        tick();
        total++; if (u_if.bank0_cs !== 4'b0000 || u_if.sram_we !== 1'b0) begin
            bad++; $display("FAIL idle_cs_we got=%b/%b exp=0000/0", u_if.bank0_cs, u_if.sram_we); end
        total++; if (u_if.sram_addr !== 13'd4) begin bad++; $display("FAIL idle_addr_hold got=%h exp=4", u_if.sram_addr); end
        set_req(0, 1'b0, 16'h0010, 2'd2, 32'h0);
        tick();
        total++; if (gnt !== 2'b01 || u_if.sram_we !== 1'b0) begin
            bad++; $display("FAIL rd_gnt got=%b we=%b exp=01 we=0", gnt, u_if.sram_we); end
        idle();
        tick();
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL rd_rvalid got=%b exp=01", rvalid); end
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_data got=%h exp=12345678", rdata); end
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL rd_rvalid_pulse got=%b exp=00", rvalid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        int n1, n0;
        hreset = 1'b1;
        idle();
        tick();
        hreset = 1'b0;
        set_req(0, 1'b1, 16'h0080, 2'd2, 32'h1111_0000);
        set_req(1, 1'b1, 16'h8080, 2'd2, 32'h2222_0000);
        for (int k = 0; k < 6; k++) begin
            tick();
`ifdef SRAM_SCHED_FIXED_PRIO_EN
            exp = (k % 2 == 0) ? 2'b01 : 2'b00;
`else
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            total++; if (gnt !== exp) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", k, gnt, exp); end
        end
        req[0] = 1'b0;
        n1 = 0;
        n0 = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (gnt[1] === 1'b1) n1++;
            if (gnt[0] === 1'b1) n0++;
        end
        total++; if (n1 != 1 || n0 != 0) begin bad++; $display("FAIL rr_drop got=%0d/%0d exp=1/0", n1, n0); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_lanes();
        set_req(0, 1'b1, 16'h8003, 2'd0, 32'hAB00_0000);
        tick();
        total++; if (u_if.bank1_cs !== 4'b1000) begin bad++; $display("FAIL byte_cs1 got=%b exp=1000", u_if.bank1_cs); end
        total++; if (u_if.bank0_cs !== 4'b0000) begin bad++; $display("FAIL byte_cs0 got=%b exp=0000", u_if.bank0_cs); end
        total++; if (u_if.sram_addr !== 13'd0) begin bad++; $display("FAIL byte_addr got=%h exp=0", u_if.sram_addr); end
        idle();
        tick();
        set_req(1, 1'b1, 16'h0002, 2'd1, 32'hCDEF_0000);
        tick();
        total++; if (u_if.bank0_cs !== 4'b1100 || u_if.bank1_cs !== 4'b0000) begin
            bad++; $display("FAIL half_cs got=%b/%b exp=1100/0000", u_if.bank0_cs, u_if.bank1_cs); end
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL half_gnt got=%b exp=10", gnt); end
        idle();
        tick();
        set_req(0, 1'b0, 16'h8003, 2'd0, 32'h0);
        tick();
        idle();
        tick();
        total++; if (rvalid !== 2'b01 || rdata[31:24] !== 8'hAB) begin
            bad++; $display("FAIL byte_rd got=%b/%h exp=01/ab", rvalid, rdata[31:24]); end
        set_req(1, 1'b0, 16'h0002, 2'd1, 32'h0);
        tick();
        idle();
        tick();
        total++; if (rvalid !== 2'b10 || rdata[31:16] !== 16'hCDEF) begin
            bad++; $display("FAIL half_rd got=%b/%h exp=10/cdef", rvalid, rdata[31:16]); end
    endtask

    task automatic test_errors();
        set_req(0, 1'b0, 16'h0002, 2'd2, 32'h0);
        tick();
        total++; if (gnt !== 2'b01 || err !== 2'b01) begin
            bad++; $display("FAIL werr_pulse got=%b/%b exp=01/01", gnt, err); end
        total++; if (u_if.bank0_cs !== 4'b0000 || u_if.bank1_cs !== 4'b0000) begin
            bad++; $display("FAIL werr_cs got=%b/%b exp=0000/0000", u_if.bank0_cs, u_if.bank1_cs); end
        idle();
        tick();
        total++; if (rvalid !== 2'b00 || err !== 2'b00) begin
            bad++; $display("FAIL werr_norv got=%b/%b exp=00/00", rvalid, err); end
        set_req(1, 1'b0, 16'h0000, 2'd3, 32'h0);
        tick();
        total++; if (gnt !== 2'b10 || err !== 2'b10) begin
            bad++; $display("FAIL s3_pulse got=%b/%b exp=10/10", gnt, err); end
        total++; if (u_if.bank0_cs !== 4'b0000 || u_if.bank1_cs !== 4'b0000) begin
            bad++; $display("FAIL s3_cs got=%b/%b exp=0000/0000", u_if.bank0_cs, u_if.bank1_cs); end
        set_req(0, 1'b0, 16'h8001, 2'd1, 32'h0);
        req[1] = 1'b0;
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL s3_norv got=%b exp=00", rvalid); end
        total++; if (gnt !== 2'b01 || err !== 2'b01) begin
            bad++; $display("FAIL herr_pulse got=%b/%b exp=01/01", gnt, err); end
        idle();
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL herr_norv got=%b exp=00", rvalid); end
    endtask

    task automatic test_reset_discard();
        set_req(0, 1'b0, 16'h0010, 2'd2, 32'h0);
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rd_pre_gnt got=%b exp=01", gnt); end
        hreset = 1'b1;
        idle();
        tick();
        total++; if (rvalid !== 2'b00 || gnt !== 2'b00 || err !== 2'b00) begin
            bad++; $display("FAIL disc_pulses got=%b/%b/%b exp=00/00/00", rvalid, gnt, err); end
        total++; if (u_if.bank0_cs !== 4'b0000 || u_if.bank1_cs !== 4'b0000 || u_if.sram_we !== 1'b0) begin
            bad++; $display("FAIL disc_bus got=%b/%b/%b exp=0", u_if.bank0_cs, u_if.bank1_cs, u_if.sram_we); end
        total++; if (u_if.sram_addr !== 13'd0 || u_if.sram_wdata !== 32'd0) begin
            bad++; $display("FAIL disc_regs got=%h/%h exp=0/0", u_if.sram_addr, u_if.sram_wdata); end
        hreset = 1'b0;
        set_req(0, 1'b0, 16'h0010, 2'd2, 32'h0);
        set_req(1, 1'b0, 16'h8000, 2'd2, 32'h0);
        tick();
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL disc_norv got=%b exp=00", rvalid); end
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL post_rst_contest got=%b exp=01", gnt); end
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  exp_gnt, exp_err, exp_rd, exp_rv, elig, sz, off;
        logic [3:0]  exp_cs0, exp_cs1, exp_rmask, rmask_pend, mask;
        logic [31:0] exp_rdata, rd_pend, m32;
        logic [12:0] exp_addr, wa;
        logic [31:0] exp_wdata;
        logic [15:0] a;
        logic        exp_we, model_prio, wv, bk, bad_acc, we;
        int          w;
        int unsigned key;

        hreset = 1'b1;
        idle();
        tick();
        hreset = 1'b0;
        exp_gnt = '0; exp_err = '0; exp_rd = '0; exp_rv = '0;
        exp_cs0 = '0; exp_cs1 = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        exp_rmask = '0; rmask_pend = '0; exp_rdata = '0; rd_pend = '0;
        model_prio = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, exp_err); end
            total++; if (rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, exp_rv); end
            total++; if (u_if.bank0_cs !== exp_cs0 || u_if.bank1_cs !== exp_cs1) begin
                bad++; $display("FAIL rnd_cs cyc=%0d got=%b/%b exp=%b/%b", cyc, u_if.bank0_cs, u_if.bank1_cs, exp_cs0, exp_cs1); end
            total++; if (u_if.sram_we !== exp_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, u_if.sram_we, exp_we); end
            if (exp_gnt != 2'b00) begin
                total++; if (u_if.sram_addr !== exp_addr) begin
                    bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, u_if.sram_addr, exp_addr); end
                if (exp_we) begin
                    total++; if (u_if.sram_wdata !== exp_wdata) begin
                        bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, u_if.sram_wdata, exp_wdata); end
                end
            end
            if (exp_rv != 2'b00) begin
                for (int l = 0; l < 4; l++) m32[8*l +: 8] = {8{exp_rmask[l]}};
                total++; if ((rdata & m32) !== (exp_rdata & m32)) begin
                    bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h mask=%b", cyc, rdata, exp_rdata, exp_rmask); end
            end

            exp_rv    = exp_rd;
            exp_rdata = rd_pend;
            exp_rmask = rmask_pend;

            for (int r = 0; r < 2; r++) begin
                if (!req[r] || exp_gnt[r]) begin
                    if ($urandom_range(0, 99) < 65) begin
                        a  = {1'($urandom_range(0, 1)), 13'(64 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                        if ($urandom_range(0, 1) == 1) begin
                            if (sz == 2'd2) a[1:0] = 2'b00;
                            else if (sz == 2'd1) a[0] = 1'b0;
                        end
                        set_req(r, 1'($urandom_range(0, 1)), a, sz, $urandom);
                    end else begin
                        req[r] = 1'b0;
                    end
                end
            end

            // Arbitration as stated: ignore the requester whose grant is showing now
            elig = req & ~exp_gnt;
`ifdef SRAM_SCHED_FIXED_PRIO_EN
            wv = elig[0] | (elig[1] & ~req[0]);
            w  = elig[0] ? 0 : 1;
`else
            wv = |elig;
            w  = (elig == 2'b11) ? int'(model_prio) : (elig[1] ? 1 : 0);
`endif
            exp_gnt = '0; exp_err = '0; exp_rd = '0;
            exp_cs0 = '0; exp_cs1 = '0; exp_we = 1'b0;
            if (wv) begin
                model_prio = (w == 0);
                sz  = req_size[w];
                off = req_addr[w][1:0];
                bk  = req_addr[w][15];
                wa  = req_addr[w][14:2];
                we  = req_we[w];
                case (sz)
                    2'd0:    mask = 4'b0001 << off;
                    2'd1:    mask = off[1] ? 4'b1100 : 4'b0011;
                    2'd2:    mask = 4'b1111;
                    default: mask = 4'b0000;
                endcase
                bad_acc = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
                exp_gnt[w] = 1'b1;
                exp_err[w] = bad_acc;
                exp_we     = we;
                exp_addr   = wa;
                exp_wdata  = req_wdata[w];
                if (!bad_acc) begin
                    if (bk) exp_cs1 = mask;
                    else    exp_cs0 = mask;
                    for (int l = 0; l < 4; l++) begin
                        key = (int'(bk) << 15) | (int'(wa) << 2) | l;
                        if (mask[l]) begin
                            if (we) ref_mem[key] = req_wdata[w][8*l +: 8];
                            else    rd_pend[8*l +: 8] = ref_rd(key);
                        end
                    end
                    if (!we) begin
                        exp_rd[w]  = 1'b1;
                        rmask_pend = mask;
                    end
                end
            end
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        hreset    = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        for (int b = 0; b < 8; b++) begin
            b_q[b] = 8'h00;
            for (int a = 0; a < 8192; a++) mem[b][a] = 8'h00;
        end

        test_reset();
        test_word_write_read();
        test_round_robin();
        test_lanes();
        test_errors();
        test_reset_discard();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_sched.md
SRAM_PORT_SCHED -- requirements
Module: sram_port_sched

Interface
REQ-001 SHALL have parameter: SRAM_DATA_WIDTH, 8, byte-lane width of each bank macro.
REQ-002 SHALL have parameter: SRAM_ADDR_WIDTH, 13, word address width per macro.
REQ-003 SHALL have parameter: DATA_WIDTH, 32, requester data width (4 lanes).
REQ-004 SHALL have port: hclk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: hreset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: req  input  [1:0]  per-requester access request.
REQ-007 SHALL have port: req_we  input  [1:0]  1 = write, 0 = read.
REQ-008 SHALL have port: req_addr  input  [1:0][SRAM_ADDR_WIDTH+2:0]  byte address; bit MSB = bank, [1:0] = byte offset.
REQ-009 SHALL have port: req_size  input  [1:0][1:0]  0 byte, 1 half, 2 word, 3 illegal.
REQ-010 SHALL have port: req_wdata  input  [1:0][DATA_WIDTH-1:0]  write data, lane-aligned.
REQ-011 SHALL have port: gnt  output  [1:0]  one-cycle grant pulse.
REQ-012 SHALL have port: err  output  [1:0]  one-cycle error pulse, coincident with gnt.
REQ-013 SHALL have port: rvalid  output  [1:0]  read data valid pulse.
REQ-014 SHALL have port: rdata  output  [DATA_WIDTH-1:0]  read data, shared by both requesters.
REQ-015 SHALL have port: sram  sram_if  interface  drives sram_we, sram_addr, sram_wdata, bank0_cs, bank1_cs; reads sram_b0..sram_b7.

Function
REQ-016 SHALL sample req at cycle N, register the winner, and in N+1 pulse gnt[winner] and drive sram signals from registers.
REQ-017 SHALL pick, when both requesters request, the one not granted most recently (round-robin); a lone requester SHALL always win.
REQ-018 SHALL ignore req[i] in any cycle where gnt[i] is high (no double grant); requester holds req and fields stable until gnt.
REQ-019 SHALL decode lanes: byte -> 1<<addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
REQ-020 SHALL route lanes to bank0_cs when bank bit = 0, bank1_cs when 1; the other bank's cs = 0.
REQ-021 SHALL drive sram_addr = req_addr[SRAM_ADDR_WIDTH+1:2], sram_wdata = req_wdata unshifted, sram_we = req_we.
REQ-022 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or size 3 as error: gnt and err pulse together, all cs = 0, no rvalid.
REQ-023 SHALL, for a legal read granted in N+1, pulse rvalid[i] in N+2 with rdata = {b3,b2,b1,b0} (bank0) or {b7,b6,b5,b4} (bank1), all lanes unmasked.
REQ-024 SHALL, in cycles with no grant, hold bank0_cs = bank1_cs = 0 and sram_we = 0; sram_addr/sram_wdata hold last value.
REQ-025 SHALL sustain one access per cycle when requests alternate; a single requester SHALL get at most one grant every 2 cycles.
REQ-026 SHALL make a write granted in N+1 visible to any read granted in N+2 or later.

Reset
REQ-027 SHALL, while hreset is high at a clock edge, clear gnt, err, rvalid, all cs, sram_we, sram_addr, sram_wdata, rdata-select state to 0.
REQ-028 SHALL reset the round-robin pointer so requester 0 wins the first contested cycle.
REQ-029 SHALL discard a read pending at reset; no rvalid after reset release until a new grant.

Configuration
REQ-030 SHALL, with SRAM_SCHED_FIXED_PRIO_EN defined, grant requester 0 whenever both request (requester 1 may starve).
REQ-031 SHALL, without SRAM_SCHED_FIXED_PRIO_EN, use round-robin per REQ-017.

Structure
REQ-032 SHALL place the size enum (BYTE/HALF/WORD/ILLEGAL), lane-decode function and bank-count constant in package sram_sched_pkg.
REQ-033 SHALL implement lane decode and error check in one combinational sub-module sram_lane_dec.

Verification
REQ-034 SHALL cover: req0 write word 0x1234_5678 @0x0010 -> gnt[0] N+1, bank0_cs=1111, sram_addr=4, we=1; later read -> rvalid[0] N+2, rdata 0x1234_5678.
REQ-035 SHALL cover: both req held 6 cycles -> grants 0,1,0,1... (round-robin); macro defined -> only gnt[0] until req0 drops.
REQ-036 SHALL cover: byte write 0xAB @0x8003 -> bank1_cs=1000, bank0_cs=0000; half @0x0002 -> bank0_cs=1100.
REQ-037 SHALL cover: word @0x0002 or size 3 -> gnt and err pulse same cycle, cs=0, no rvalid.
REQ-038 SHALL cover: hreset asserted the cycle after a read grant -> no rvalid, all outputs 0, first post-reset contest won by requester 0.
